// File: rtl/seq_mem_pkg.sv
// Shared types for the sequential-memory arbiter: FSM states, operation codes
// and a small one-hot helper used for grant and read-valid decoding.
package seq_mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    typedef enum logic {
        OP_WRITE = 1'b0,
        OP_READ  = 1'b1
    } op_t;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/seq_mem_arbiter_if.sv
// Bundle of client-side and memory-side signals around seq_mem_arbiter.
// The arbiter uses the slave view; clients plus the memory use the master view.
interface seq_mem_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [1:0]              cli_req_write;
    logic [1:0]              cli_req_read;
    logic [2*DATA_WIDTH-1:0] cli_data_in;
    logic [1:0]              cli_grant;
    logic [1:0]              cli_rd_valid;
    logic [DATA_WIDTH-1:0]   rd_data;

    logic                    mem_request_write;
    logic                    mem_request_read;
    logic [DATA_WIDTH-1:0]   mem_data_in;
    logic [DATA_WIDTH-1:0]   mem_data_out;

    logic [CW-1:0]           count;
    logic                    full;
    logic                    empty;

    modport slave (
        input  cli_req_write, cli_req_read, cli_data_in, mem_data_out,
        output cli_grant, cli_rd_valid, rd_data,
        output mem_request_write, mem_request_read, mem_data_in,
        output count, full, empty
    );

    modport master (
        output cli_req_write, cli_req_read, cli_data_in, mem_data_out,
        input  cli_grant, cli_rd_valid, rd_data,
        input  mem_request_write, mem_request_read, mem_data_in,
        input  count, full, empty
    );

endinterface

// File: rtl/seq_mem_arbiter_rr.sv
// Two-way round-robin selector: on a tie the client not granted last wins;
// the tie-break pointer moves only when the caller reports a grant.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       grant_idx
);

    logic prio_q;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        grant_idx = 1'b0;
        case (req)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = prio_q;
            default: grant_idx = 1'b0;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_q <= 1'b0;
        end else if (advance) begin
            prio_q <= ~grant_idx;
        end
    end

endmodule

// File: rtl/seq_mem_arbiter.sv
// Two-client arbiter in front of a sequential (FIFO-ordered) memory: one
// operation in flight, IDLE -> ISSUE (-> CAPTURE for reads) -> IDLE.
module seq_mem_arbiter
    import seq_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic             clk,
    input  logic             reset,
    seq_mem_arbiter_if.slave bus
);

    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    state_t                state;
    op_t                   op_q;
    logic                  client_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [1:0]            rd_valid_q;
    logic [CW-1:0]         count_q;

    logic                  wr_ok;
    logic                  rd_ok;
    logic [1:0]            rd_elig;
    logic [1:0]            wr_elig;
    logic [1:0]            elig;
    logic                  sel_idx;
    logic                  sel_fire;
    op_t                   sel_op;
    logic [DATA_WIDTH-1:0] sel_data;

    // Ineligible requests are masked here, so they stay pending without
    // being granted and never move the round-robin pointer.
    assign wr_ok    = (count_q < DEPTH_C);
    assign rd_ok    = (count_q != '0);
    assign rd_elig  = bus.cli_req_read  & {2{rd_ok}};
    assign wr_elig  = bus.cli_req_write & {2{wr_ok}};
    assign elig     = rd_elig | wr_elig;
    assign sel_fire = (state == IDLE) && (elig != 2'b00);

    rr_arbiter2 u_rr (
        .clk       (clk),
        .reset     (reset),
        .req       (elig),
        .advance   (sel_fire),
        .grant_idx (sel_idx)
    );

    assign sel_op   = rd_elig[sel_idx] ? OP_READ : OP_WRITE;
    assign sel_data = sel_idx ? bus.cli_data_in[2*DATA_WIDTH-1:DATA_WIDTH]
                              : bus.cli_data_in[DATA_WIDTH-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            op_q      <= OP_WRITE;
            client_q  <= 1'b0;
            wr_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_fire) begin
                        state     <= ISSUE;
                        op_q      <= sel_op;
                        client_q  <= sel_idx;
                        wr_data_q <= sel_data;
                    end
                end
                ISSUE:   state <= (op_q == OP_READ) ? CAPTURE : IDLE;
                CAPTURE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Occupancy tracks the memory at the end of the pulse cycle; the
    // eligibility mask guarantees it never wraps in either direction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (state == ISSUE) begin
            if (op_q == OP_WRITE) begin
                count_q <= count_q + CW'(1);
            end else begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Memory data is valid during CAPTURE; register it so rd_data and the
    // valid pulse line up one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 2'b00;
        end else begin
            rd_valid_q <= 2'b00;
            if (state == CAPTURE) begin
                rd_data_q  <= bus.mem_data_out;
                rd_valid_q <= onehot2(client_q);
            end
        end
    end

    assign bus.cli_grant         = (state == ISSUE) ? onehot2(client_q) : 2'b00;
    assign bus.mem_request_write = (state == ISSUE) && (op_q == OP_WRITE);
    assign bus.mem_request_read  = (state == ISSUE) && (op_q == OP_READ);
    assign bus.mem_data_in       = wr_data_q;
    assign bus.cli_rd_valid      = rd_valid_q;
    assign bus.rd_data           = rd_data_q;
    assign bus.count             = count_q;
    assign bus.full              = (count_q == DEPTH_C);
    assign bus.empty             = (count_q == '0);

endmodule

// File: tb/tb_seq_mem_arbiter.sv
// Directed bench for seq_mem_arbiter with a behavioural FIFO-ordered
// sequential_memory: cycle-vector table plus hand-written multi-cycle sequences.
module tb_seq_mem_arbiter;

    localparam int DW = 8;
    localparam int DP = 16;

    logic clk;
    logic reset;

    seq_mem_arbiter_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bus ();

    seq_mem_arbiter #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // sequential_memory: write appends, read returns the oldest word next cycle
    logic [DW-1:0] mem_arr [DP];
    logic [3:0]    mem_wp;
    logic [3:0]    mem_rp;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_wp           <= '0;
            mem_rp           <= '0;
            bus.mem_data_out <= '0;
        end else begin
            if (bus.mem_request_write) begin
                mem_arr[mem_wp] <= bus.mem_data_in;
                mem_wp          <= mem_wp + 4'd1;
            end
            if (bus.mem_request_read) begin
                bus.mem_data_out <= mem_arr[mem_rp];
                mem_rp           <= mem_rp + 4'd1;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [1:0]    wr;
        logic [1:0]    rd;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic [1:0]    grant;
        logic          mwr;
        logic          mrd;
        logic [DW-1:0] mdin;
        logic [1:0]    rvalid;
        logic [DW-1:0] rdata;
        logic [4:0]    count;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [1:0] wr, input logic [1:0] rd,
                                input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                input logic [1:0] grant, input logic mwr, input logic mrd,
                                input logic [DW-1:0] mdin, input logic [1:0] rvalid,
                                input logic [DW-1:0] rdata, input logic [4:0] count);
        vec_t v;
        v.wr = wr; v.rd = rd; v.d0 = d0; v.d1 = d1;
        v.grant = grant; v.mwr = mwr; v.mrd = mrd; v.mdin = mdin;
        v.rvalid = rvalid; v.rdata = rdata; v.count = count;
        return v;
    endfunction

    // Read by one client, optionally with a write request held alongside;
    // checks grant, pulse kind, grant-to-valid latency and returned word.
    task automatic do_read(input logic idx, input logic [1:0] wr_mask, input logic [DW-1:0] exp_data);
        logic [1:0] oh;
        bit         seen;
        int         lat;
        oh   = idx ? 2'b10 : 2'b01;
        seen = 1'b0;
        lat  = 0;
        bus.cli_req_read  = oh;
        bus.cli_req_write = wr_mask;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(posedge clk); #1;
            if (bus.cli_grant != 2'b00) seen = 1'b1;
        end
        check("rd.grant", 32'(bus.cli_grant), 32'(oh));
        check("rd.mem_read", 32'(bus.mem_request_read), 32'd1);
        check("rd.mem_write", 32'(bus.mem_request_write), 32'd0);
        bus.cli_req_read  = 2'b00;
        bus.cli_req_write = 2'b00;
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(posedge clk); #1;
            lat++;
            if (bus.cli_rd_valid != 2'b00) seen = 1'b1;
        end
        check("rd.valid", 32'(bus.cli_rd_valid), 32'(oh));
        check("rd.latency", 32'(lat), 32'd2);
        check("rd.data", 32'(bus.rd_data), 32'(exp_data));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       v;
        logic [7:0] next0;
        logic [7:0] next1;
        logic       exp_cl;
        int         n_grants;

        // cycle vectors: inputs held for one cycle, outputs checked #1 after the edge
        vecs[0]  = mk(2'b01, 2'b00, 8'h11, 8'h00, 2'b01, 1, 0, 8'h11, 2'b00, 8'h00, 5'd0);
        vecs[1]  = mk(2'b00, 2'b00, 8'h11, 8'h00, 2'b00, 0, 0, 8'h00, 2'b00, 8'h00, 5'd1);
        vecs[2]  = mk(2'b00, 2'b01, 8'h00, 8'h00, 2'b01, 0, 1, 8'h00, 2'b00, 8'h00, 5'd1);
        vecs[3]  = mk(2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 0, 0, 8'h00, 2'b00, 8'h00, 5'd0);
        vecs[4]  = mk(2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 0, 0, 8'h00, 2'b01, 8'h11, 5'd0);
        vecs[5]  = mk(2'b00, 2'b10, 8'h00, 8'h00, 2'b00, 0, 0, 8'h00, 2'b00, 8'h00, 5'd0);
        vecs[6]  = mk(2'b00, 2'b10, 8'h00, 8'h00, 2'b00, 0, 0, 8'h00, 2'b00, 8'h00, 5'd0);
        vecs[7]  = mk(2'b01, 2'b10, 8'h5C, 8'h00, 2'b01, 1, 0, 8'h5C, 2'b00, 8'h00, 5'd0);
        vecs[8]  = mk(2'b00, 2'b10, 8'h5C, 8'h00, 2'b00, 0, 0, 8'h00, 2'b00, 8'h00, 5'd1);
        vecs[9]  = mk(2'b00, 2'b10, 8'h00, 8'h00, 2'b10, 0, 1, 8'h00, 2'b00, 8'h00, 5'd1);
        vecs[10] = mk(2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 0, 0, 8'h00, 2'b00, 8'h00, 5'd0);
        vecs[11] = mk(2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 0, 0, 8'h00, 2'b10, 8'h5C, 5'd0);
        vecs[12] = mk(2'b10, 2'b00, 8'h00, 8'h31, 2'b10, 1, 0, 8'h31, 2'b00, 8'h00, 5'd0);
        vecs[13] = mk(2'b00, 2'b00, 8'h00, 8'h31, 2'b00, 0, 0, 8'h00, 2'b00, 8'h00, 5'd1);
        vecs[14] = mk(2'b10, 2'b00, 8'h00, 8'h32, 2'b10, 1, 0, 8'h32, 2'b00, 8'h00, 5'd1);
        vecs[15] = mk(2'b00, 2'b00, 8'h00, 8'h32, 2'b00, 0, 0, 8'h00, 2'b00, 8'h00, 5'd2);
        vecs[16] = mk(2'b10, 2'b00, 8'h00, 8'h33, 2'b10, 1, 0, 8'h33, 2'b00, 8'h00, 5'd2);
        vecs[17] = mk(2'b00, 2'b00, 8'h00, 8'h33, 2'b00, 0, 0, 8'h00, 2'b00, 8'h00, 5'd3);
        vecs[18] = mk(2'b10, 2'b01, 8'h00, 8'h44, 2'b01, 0, 1, 8'h00, 2'b00, 8'h00, 5'd3);
        vecs[19] = mk(2'b10, 2'b00, 8'h00, 8'h44, 2'b00, 0, 0, 8'h00, 2'b00, 8'h00, 5'd2);
        vecs[20] = mk(2'b10, 2'b00, 8'h00, 8'h44, 2'b00, 0, 0, 8'h00, 2'b01, 8'h31, 5'd2);
        vecs[21] = mk(2'b10, 2'b00, 8'h00, 8'h44, 2'b10, 1, 0, 8'h44, 2'b00, 8'h00, 5'd2);
        vecs[22] = mk(2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 0, 0, 8'h00, 2'b00, 8'h00, 5'd3);
        vecs[23] = mk(2'b00, 2'b01, 8'h00, 8'h00, 2'b01, 0, 1, 8'h00, 2'b00, 8'h00, 5'd3);
        vecs[24] = mk(2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 0, 0, 8'h00, 2'b00, 8'h00, 5'd2);
        vecs[25] = mk(2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 0, 0, 8'h00, 2'b01, 8'h32, 5'd2);

        reset             = 1'b0;
        bus.cli_req_write = 2'b00;
        bus.cli_req_read  = 2'b00;
        bus.cli_data_in   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.count", 32'(bus.count), 32'd0);
        check("rst.empty", 32'(bus.empty), 32'd1);
        check("rst.full", 32'(bus.full), 32'd0);
        check("rst.grant", 32'(bus.cli_grant), 32'd0);
        check("rst.rd_valid", 32'(bus.cli_rd_valid), 32'd0);
        check("rst.mem_pulses", 32'({bus.mem_request_write, bus.mem_request_read}), 32'd0);
        check("rst.rd_data", 32'(bus.rd_data), 32'd0);
        check("rst.mem_data_in", 32'(bus.mem_data_in), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            bus.cli_req_write = v.wr;
            bus.cli_req_read  = v.rd;
            bus.cli_data_in   = {v.d1, v.d0};
            @(posedge clk); #1;
            check($sformatf("v%0d.grant", i), 32'(bus.cli_grant), 32'(v.grant));
            check($sformatf("v%0d.mem_write", i), 32'(bus.mem_request_write), 32'(v.mwr));
            check($sformatf("v%0d.mem_read", i), 32'(bus.mem_request_read), 32'(v.mrd));
            check($sformatf("v%0d.rd_valid", i), 32'(bus.cli_rd_valid), 32'(v.rvalid));
            check($sformatf("v%0d.count", i), 32'(bus.count), 32'(v.count));
            check($sformatf("v%0d.full", i), 32'(bus.full), 32'(v.count == 5'd16));
            check($sformatf("v%0d.empty", i), 32'(bus.empty), 32'(v.count == 5'd0));
            if (v.mwr) check($sformatf("v%0d.mem_data_in", i), 32'(bus.mem_data_in), 32'(v.mdin));
            if (v.rvalid != 2'b00) check($sformatf("v%0d.rd_data", i), 32'(bus.rd_data), 32'(v.rdata));
        end

        // reset while a read sits in CAPTURE: no valid pulse may follow
        bus.cli_req_read = 2'b01;
        @(posedge clk); #1;
        check("abort.grant", 32'(bus.cli_grant), 32'd1);
        bus.cli_req_read = 2'b00;
        @(posedge clk); #1;
        check("abort.count_before", 32'(bus.count), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("abort.count", 32'(bus.count), 32'd0);
        check("abort.empty", 32'(bus.empty), 32'd1);
        check("abort.rd_data", 32'(bus.rd_data), 32'd0);
        check("abort.mem_data_in", 32'(bus.mem_data_in), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("abort.c%0d.outs", c),
                  32'({bus.cli_grant, bus.cli_rd_valid, bus.mem_request_write, bus.mem_request_read}),
                  32'd0);
            check($sformatf("abort.c%0d.count", c), 32'(bus.count), 32'd0);
        end

        // both clients stream writes until full; grants must alternate 0,1,0,1
        next0             = 8'hA0;
        next1             = 8'hB0;
        exp_cl            = 1'b0;
        n_grants          = 0;
        bus.cli_data_in   = {next1, next0};
        bus.cli_req_write = 2'b11;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (bus.cli_grant != 2'b00) begin
                n_grants++;
                check("rr.grant", 32'(bus.cli_grant), 32'(exp_cl ? 2'b10 : 2'b01));
                check("rr.wdata", 32'(bus.mem_data_in), 32'(exp_cl ? next1 : next0));
                if (bus.cli_grant[1]) next1 = next1 + 8'd1;
                else                  next0 = next0 + 8'd1;
                bus.cli_data_in = {next1, next0};
                exp_cl          = ~exp_cl;
            end
        end
        check("rr.n_grants", 32'(n_grants), 32'd16);
        check("rr.count", 32'(bus.count), 32'd16);
        check("rr.full", 32'(bus.full), 32'd1);
        check("rr.empty", 32'(bus.empty), 32'd0);
        bus.cli_req_write = 2'b00;

        // drain in FIFO order; client0 holding both read and write gets the read
        do_read(1'b1, 2'b00, 8'hA0);
        do_read(1'b0, 2'b00, 8'hB0);
        bus.cli_data_in = {8'h00, 8'h77};
        do_read(1'b0, 2'b01, 8'hA1);
        check("drain.count", 32'(bus.count), 32'd13);
        check("drain.full", 32'(bus.full), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
